// File: rtl/mdr_mem_sequencer.sv
// LC-3 memory sequencer: round-robin arbitration of two requesters onto one SRAM port
// via internal MAR/MDR registers. Flow per access: IDLE -> LATCH -> ACCESS -> DONE.
module mdr_mem_sequencer #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic [1:0]        req_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              LD_MAR,
    output logic              LD_MDR,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
        $error("mdr_mem_sequencer: WAIT_CYCLES must be >= 1");
    end

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LATCH, S_ACCESS, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mar_q        <= '0;
            mdr_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mar_d        = mar_q;
        mdr_d        = mdr_q;
        rdata_d      = rdata_q;
        req_ready    = 2'b00;
        LD_MAR       = 1'b0;
        LD_MDR       = 1'b0;
        mem_ce_n     = 1'b1;
        mem_oe_n     = 1'b1;
        mem_we_n     = 1'b1;
        mem_wdata_oe = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    // Contention goes to whichever port was not served last.
                    grant_d = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
                    we_d    = req_we[grant_d];
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                LD_MAR = 1'b1;
                mar_d  = grant_q ? req1_addr : req0_addr;
                if (we_q) begin
                    LD_MDR = 1'b1;
                    mdr_d  = grant_q ? req1_wdata : req0_wdata;
                end
                cnt_d   = CNT_INIT;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                mem_ce_n     = 1'b0;
                mem_oe_n     = we_q;
                mem_we_n     = ~we_q;
                mem_wdata_oe = we_q;
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        LD_MDR = 1'b1;
                        mdr_d  = mem_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                req_ready[grant_q] = 1'b1;
                last_grant_d       = grant_q;
                mem_wdata_oe       = we_q;  // write data held one extra cycle for SRAM hold time
                if (!we_q) rdata_d = mdr_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // During a read's DONE cycle the fresh MDR is shown before rdata_q captures it.
    assign rdata     = (state_q == S_DONE && !we_q) ? mdr_q : rdata_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

endmodule
